bpsk_tx_controller: RTL and testbench

- Frame sequencer for the BPSK modulator datapath.
- Accepts payload words from an upstream source over a valid/ready handshake.
- Drives the modulator's enable, sample-counter and data inputs so that each word is committed exactly at a word boundary.
- Wraps every frame with a preamble, pads on underrun, and enforces an inter-frame gap with the modulator disabled.

---
 rtl/bpsk_tx_controller.sv | 160 ++++++++++++++++
 tb/tb_bpsk_tx_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_tx_controller.sv
// Frame sequencer for the BPSK modulator: preamble, payload staging with
// underrun padding, flush of the last word and a modulator-off inter-frame gap.
module bpsk_tx_controller #(
  parameter int                    SAMPLE_NUMBER = 256,
  parameter int                    DATA_WIDTH    = 12,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE_WORD = 12'hF0F,
  parameter int                    PREAMBLE_LEN  = 2,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD      = 12'h000,
  parameter int                    GAP_PERIODS   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             s_last,
  output logic                             s_ready,
  output logic                             mod_en,
  output logic [$clog2(SAMPLE_NUMBER)-1:0] mod_cnt,
  output logic [DATA_WIDTH-1:0]            mod_data,
  output logic                             tx_active,
  output logic                             underrun,
  output logic                             frame_done,
  output logic                             busy
);

  localparam int CW = $clog2(SAMPLE_NUMBER);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam int GW = $clog2(GAP_PERIODS + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(SAMPLE_NUMBER - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(DATA_WIDTH - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_PERIODS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_PAY   = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_cnt;
  logic [PW-1:0]         pre_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [DATA_WIDTH-1:0] stage_data;
  logic                  stage_full;
  logic                  stage_last;
  logic                  last_taken;
  logic                  running;
  logic                  boundary;
  logic                  handshake;

  assign running   = (state != S_IDLE);
  assign boundary  = running && (cnt == CNT_MAX) && (bit_cnt == BIT_MAX);
  assign s_ready   = (state == S_PAY) && !stage_full && !last_taken;
  assign handshake = s_valid && s_ready;

  assign mod_en     = (state == S_FILL) || (state == S_PRE) ||
                      (state == S_PAY)  || (state == S_FLUSH);
  assign tx_active  = (state == S_PRE) || (state == S_PAY) || (state == S_FLUSH);
  assign underrun   = (state == S_PAY) && boundary && !stage_full;
  assign frame_done = (state == S_GAP) && boundary && (gap_cnt == GAP_LAST);
  assign busy       = running;
  assign mod_cnt    = cnt;
  assign mod_data   = stage_data;

  // Sample and bit counters; a word period ends when both wrap together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (!running) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt     <= '0;
      bit_cnt <= (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pre_cnt    <= '0;
      gap_cnt    <= '0;
      stage_data <= PREAMBLE_WORD;
      stage_full <= 1'b0;
      stage_last <= 1'b0;
      last_taken <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_valid) state <= S_FILL;
        end
        S_FILL: begin
          if (boundary) begin
            pre_cnt <= PW'(1);
            if (PREAMBLE_LEN == 1) begin
              stage_data <= PAD_WORD;
              state      <= S_PAY;
            end else begin
              state <= S_PRE;
            end
          end
        end
        S_PRE: begin
          if (boundary) begin
            pre_cnt <= pre_cnt + 1'b1;
            if (pre_cnt == PRE_LAST) begin
              stage_data <= PAD_WORD;
              state      <= S_PAY;
            end
          end
        end
        S_PAY: begin
          // s_ready implies an empty stage, so the commit and a new handshake
          // never contend; a handshake on a boundary lands after the commit.
          if (boundary && stage_full) begin
            stage_full <= 1'b0;
            stage_last <= 1'b0;
            stage_data <= PAD_WORD;
            if (stage_last) state <= S_FLUSH;
          end
          if (handshake) begin
            stage_data <= s_data;
            stage_full <= 1'b1;
            stage_last <= s_last;
            if (s_last) last_taken <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (boundary) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (boundary) begin
            if (gap_cnt == GAP_LAST) begin
              state      <= S_IDLE;
              gap_cnt    <= '0;
              pre_cnt    <= '0;
              stage_data <= PREAMBLE_WORD;
              last_taken <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_tx_controller.sv
// Self-checking bench for bpsk_tx_controller: word-period model checked every
// cycle, directed timing anchors, and randomized multi-frame traffic.
module tb_bpsk_tx_controller;

  localparam int S    = 8;
  localparam int DW   = 4;
  localparam int PL   = 2;
  localparam int GAP  = 1;
  localparam int P    = S * DW;
  localparam logic [DW-1:0] PRE = 4'hA;
  localparam logic [DW-1:0] PAD = 4'h0;
  localparam int unsigned BIG = 32'h0FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          mod_en;
  logic [2:0]    mod_cnt;
  logic [DW-1:0] mod_data;
  logic          tx_active;
  logic          underrun;
  logic          frame_done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];

  bpsk_tx_controller #(
    .SAMPLE_NUMBER(S),
    .DATA_WIDTH(DW),
    .PREAMBLE_WORD(PRE),
    .PREAMBLE_LEN(PL),
    .PAD_WORD(PAD),
    .GAP_PERIODS(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_last(s_last),
    .s_ready(s_ready),
    .mod_en(mod_en),
    .mod_cnt(mod_cnt),
    .mod_data(mod_data),
    .tx_active(tx_active),
    .underrun(underrun),
    .frame_done(frame_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Frame model: position inside a frame is a word-period index plus offset;
  // segment boundaries follow from the period in which the last word committed.
  bit            act;
  int unsigned   ft, w, pos, end_w;
  bit            bnd, pay, gap_w;
  bit            st_v, st_l, tk_l;
  logic [DW-1:0] st_d, e_data, exp_w;
  bit            e_en, e_tx, e_rdy, e_und, e_fd, e_busy;
  int unsigned   e_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      act = 0; ft = 0; st_v = 0; st_l = 0; tk_l = 0; st_d = '0; end_w = BIG;
      exp_q.delete();
      check("rst_mod_en", mod_en, 0);
      check("rst_mod_data", mod_data, PRE);
      check("rst_mod_cnt", mod_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_tx_active", tx_active, 0);
    end else begin
      if (act) begin
        w      = (ft - 1) / P;
        pos    = (ft - 1) % P;
        bnd    = (pos == P - 1);
        pay    = (w >= PL) && (w < end_w);
        gap_w  = (w > end_w);
        e_en   = (w <= end_w);
        e_tx   = (w >= 1) && (w <= end_w);
        e_cnt  = pos % S;
        e_data = (w < PL) ? PRE : (st_v ? st_d : PAD);
        e_rdy  = pay && !st_v && !tk_l;
        e_und  = pay && bnd && !st_v;
        e_fd   = gap_w && (w == end_w + GAP) && bnd;
        e_busy = 1;
      end else begin
        w = 0; pos = 0; bnd = 0; pay = 0; gap_w = 0;
        e_en = 0; e_tx = 0; e_cnt = 0; e_data = PRE;
        e_rdy = 0; e_und = 0; e_fd = 0; e_busy = 0;
      end
      check("mod_en", mod_en, e_en);
      check("tx_active", tx_active, e_tx);
      check("mod_cnt", mod_cnt, e_cnt);
      check("mod_data", mod_data, e_data);
      check("s_ready", s_ready, e_rdy);
      check("underrun", underrun, e_und);
      check("frame_done", frame_done, e_fd);
      check("busy", busy, e_busy);

      if (!act) begin
        if (s_valid) begin
          act = 1; ft = 1; end_w = BIG; st_v = 0; st_l = 0; tk_l = 0;
        end
      end else begin
        if (pay && bnd && st_v) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL commit_order: got %0h, expected no word (t=%0t)", mod_data, $time);
          end else begin
            exp_w = exp_q.pop_front();
            check("commit_order", mod_data, exp_w);
          end
          if (st_l) end_w = w + 1;
          st_v = 0;
        end
        if (e_rdy && s_valid) begin
          st_v = 1; st_d = s_data; st_l = s_last;
          if (s_last) tk_l = 1;
        end
        if (e_fd) act = 0;
        else ft++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      step();
      n++;
    end
    check(name, busy, 0);
  endtask

  // Single-word frame with cycle-exact anchors; cycle 0 is the current cycle.
  task automatic run_directed(input bit do_reset, input bit do_gap);
    int          lim;
    int          hs_k;
    bit          hs;
    lim  = do_reset ? 80 : (do_gap ? 230 : 162);
    hs_k = -1;
    s_valid = 1; s_data = 4'h5; s_last = 1;
    exp_q.push_back(4'h5);
    for (int k = 0; k <= lim; k++) begin
      #1;
      case (k)
        0:   begin check("d_en_c0", mod_en, 0); check("d_busy_c0", busy, 0); end
        1:   begin check("d_en_c1", mod_en, 1); check("d_busy_c1", busy, 1); end
        32:  begin check("d_data_c32", mod_data, 4'hA); check("d_cnt_c32", mod_cnt, 7);
                   check("d_tx_c32", tx_active, 0); end
        33:  check("d_tx_c33", tx_active, 1);
        64:  begin check("d_rdy_c64", s_ready, 0); check("d_data_c64", mod_data, 4'hA); end
        65:  check("d_rdy_c65", s_ready, 1);
        96:  check("d_data_c96", mod_data, 4'h5);
        97:  check("d_data_c97", mod_data, 4'h0);
        128: check("d_en_c128", mod_en, 1);
        129: check("d_en_c129", mod_en, 0);
        150: if (do_gap) check("d_rdy_gap", s_ready, 0);
        159: check("d_fd_c159", frame_done, 0);
        160: check("d_fd_c160", frame_done, 1);
        161: check("d_busy_c161", busy, 0);
        default: ;
      endcase
      if (do_reset && k == 80) begin
        rst_n = 0;
        #1;
        check("a_rst_en", mod_en, 0);
        check("a_rst_data", mod_data, 4'hA);
        check("a_rst_busy", busy, 0);
        check("a_rst_tx", tx_active, 0);
        check("a_rst_cnt", mod_cnt, 0);
        break;
      end
      hs = s_valid && s_ready;
      if (hs) hs_k = k;
      step();
      if (hs) s_valid = 0;
      if (do_gap && k + 1 == 140) begin
        s_valid = 1; s_data = 4'h7; s_last = 1;
        exp_q.push_back(4'h7);
      end
    end
    if (do_gap) check("d_hs_next_frame", hs_k, 226);
    else if (!do_reset) check("d_hs_c65", hs_k, 65);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l, input int unsigned dly);
    bit hs;
    hs = 0;
    s_valid = 0;
    repeat (dly) step();
    s_valid = 1; s_data = d; s_last = l;
    exp_q.push_back(d);
    for (int i = 0; i < 3000; i++) begin
      #1;
      hs = s_ready;
      step();
      if (hs) break;
    end
    if (!hs) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: got no s_ready, expected handshake (t=%0t)", $time);
    end
    s_valid = 0;
  endtask

  initial begin
    int unsigned n, dly;
    rst_n = 0; s_valid = 0; s_data = '0; s_last = 0;
    repeat (3) step();
    rst_n = 1;

    run_directed(1, 0);
    step();
    step();
    rst_n = 1;
    run_directed(0, 1);
    wait_idle("idle_after_directed");

    for (int f = 0; f < 14; f++) begin
      n = $urandom_range(1, 4);
      if (f == 3) n = 4;
      for (int unsigned i = 0; i < n; i++) begin
        if (f == 3) dly = 0;
        else if (i == 0 && $urandom_range(0, 3) == 0) dly = $urandom_range(100, 200);
        else if ($urandom_range(0, 4) == 0) dly = $urandom_range(20, 60);
        else dly = $urandom_range(0, 3);
        send(4'($urandom), (i == n - 1), dly);
      end
    end
    wait_idle("idle_after_random");
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
